// File: rtl/aes_key_pkg.sv
// rtl/aes_key_pkg.sv - shared key widths, key mode and load FSM state types, key mask helper
package aes_key_pkg;

  localparam int KEY_W = 256;

  typedef enum logic [1:0] {
    KM_128 = 2'b00,
    KM_192 = 2'b01,
    KM_256 = 2'b10
  } key_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DROP,
    WAIT_RDY,
    DONE
  } keyload_state_t;

  // Bits of a right-aligned key that are meaningful for a given mode; 2'b11 never reaches capture.
  function automatic logic [KEY_W-1:0] key_mask(input logic [1:0] mode);
    case (mode)
      KM_128:  key_mask = {{(KEY_W-128){1'b0}}, {128{1'b1}}};
      KM_192:  key_mask = {{(KEY_W-192){1'b0}}, {192{1'b1}}};
      default: key_mask = {KEY_W{1'b1}};
    endcase
  endfunction

endpackage

// File: rtl/key_load_ctrl_if.sv
// rtl/key_load_ctrl_if.sv - host request/completion and key bus signals of the key load controller
interface key_load_ctrl_if;
  import aes_key_pkg::*;

  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_in;
  logic [1:0]       key_mode_in;
  logic             key_done;
  logic             key_err;
  logic             busy;
  logic [KEY_W-1:0] kb_key;
  logic [1:0]       kb_key_mode;
  logic             kb_start;
  logic             kb_key_ready;

  modport master (
    input  key_valid, key_in, key_mode_in, kb_key_ready,
    output key_ready, key_done, key_err, busy, kb_key, kb_key_mode, kb_start
  );

  modport slave (
    output key_valid, key_in, key_mode_in, kb_key_ready,
    input  key_ready, key_done, key_err, busy, kb_key, kb_key_mode, kb_start
  );

endinterface

// File: rtl/keyload_timer.sv
// rtl/keyload_timer.sv - per-phase wait counter that flags the last allowed cycle
module keyload_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Count cycles spent in the current wait phase; clear restarts it at phase entry.
  always_ff @(posedge clk) begin
    if (!resetN || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/key_load_ctrl.sv
// rtl/key_load_ctrl.sv - key bus initiator: host handshake, start pulse, ready tracking; KEYLOAD_TIMEOUT_EN adds wait timeouts
module key_load_ctrl
  import aes_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           resetN,
  key_load_ctrl_if.master bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("key_load_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  keyload_state_t state;
  logic           timeout_hit;

`ifdef KEYLOAD_TIMEOUT_EN
  logic timer_clear;
  logic timer_enable;

  // Restart the counter on entry to each wait phase and run it while waiting.
  always_comb begin
    timer_clear  = (state == START) || ((state == WAIT_DROP) && !bus.kb_key_ready);
    timer_enable = (state == WAIT_DROP) || (state == WAIT_RDY);
  end

  keyload_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .resetN (resetN),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Load sequencer; every host and key bus output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state           <= IDLE;
      bus.key_ready   <= 1'b1;
      bus.key_done    <= 1'b0;
      bus.key_err     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.kb_key      <= '0;
      bus.kb_key_mode <= 2'b00;
      bus.kb_start    <= 1'b0;
    end else begin
      bus.key_done <= 1'b0;
      bus.kb_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.key_valid && bus.key_ready) begin
            if (bus.key_mode_in == 2'b11) begin
              bus.key_err <= 1'b1;
            end else begin
              bus.kb_key      <= bus.key_in & key_mask(bus.key_mode_in);
              bus.kb_key_mode <= bus.key_mode_in;
              bus.key_err     <= 1'b0;
              bus.kb_start    <= 1'b1;
              bus.key_ready   <= 1'b0;
              bus.busy        <= 1'b1;
              state           <= START;
            end
          end
        end
        START: begin
          state <= WAIT_DROP;
        end
        WAIT_DROP: begin
          if (!bus.kb_key_ready) begin
            state <= WAIT_RDY;
          end else if (timeout_hit) begin
            bus.key_err   <= 1'b1;
            bus.key_ready <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        WAIT_RDY: begin
          if (bus.kb_key_ready) begin
            bus.key_done <= 1'b1;
            state        <= DONE;
          end else if (timeout_hit) begin
            bus.key_err   <= 1'b1;
            bus.key_ready <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        DONE: begin
          bus.key_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          bus.key_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_load_ctrl.sv
// tb/tb_key_load_ctrl.sv - directed scoreboard bench for key_load_ctrl (timeout case under KEYLOAD_TIMEOUT_EN)
module tb_key_load_ctrl;
  import aes_key_pkg::*;

  typedef struct {
    logic [255:0] key;
    logic [1:0]   mode;
  } exp_t;

  logic clk = 1'b0;
  logic resetN;

  key_load_ctrl_if kif();

  key_load_ctrl #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (kif)
  );

  always #5 clk = ~clk;

  exp_t start_q[$];
  exp_t done_q[$];
  exp_t mon_e;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   n_start    = 0;
  int   n_done     = 0;
  int   exp_starts = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_key(input logic [255:0] k, input logic [1:0] m);
    logic [255:0] r;
    r = k;
    if (m == 2'b00) r[255:128] = '0;
    if (m == 2'b01) r[255:192] = '0;
    return r;
  endfunction

  // Offer a request at a negedge, wait (bounded) for acceptance, return at the negedge after the accepting edge.
  task automatic send(input logic [255:0] k, input logic [1:0] m, input bit hold);
    int w;
    exp_t e;
    w = 0;
    kif.key_valid   = 1'b1;
    kif.key_in      = k;
    kif.key_mode_in = m;
    if (m != 2'b11) begin
      e.key  = model_key(k, m);
      e.mode = m;
      start_q.push_back(e);
      done_q.push_back(e);
      exp_starts++;
    end
    while (kif.key_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", kif.key_ready, 1);
    @(negedge clk);
    if (!hold) kif.key_valid = 1'b0;
  endtask

  // From the START-cycle negedge: ready drops, rises a cycle later; ends at the DONE negedge.
  task automatic quick_complete();
    chk("start_pulse", kif.kb_start, 1);
    chk("busy_start", kif.busy, 1);
    chk("ready_low_busy", kif.key_ready, 0);
    kif.kb_key_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    kif.kb_key_ready = 1'b1;
    @(negedge clk);
    chk("done_min_latency", kif.key_done, 1);
    chk("ready_low_in_done", kif.key_ready, 0);
  endtask

  // Scoreboard side: every start/done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (resetN === 1'b1) begin
      if (kif.kb_start === 1'b1) begin
        n_start++;
        chk("start_expected", start_q.size() != 0, 1);
        if (start_q.size() != 0) begin
          mon_e = start_q.pop_front();
          chk("kb_key_at_start", kif.kb_key, mon_e.key);
          chk("kb_mode_at_start", kif.kb_key_mode, mon_e.mode);
        end
      end
      if (kif.key_done === 1'b1) begin
        n_done++;
        chk("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          mon_e = done_q.pop_front();
          chk("kb_key_at_done", kif.kb_key, mon_e.key);
          chk("kb_mode_at_done", kif.kb_key_mode, mon_e.mode);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] k;
    int ns;
    int nd;

    resetN           = 1'b0;
    kif.key_valid    = 1'b0;
    kif.key_in       = '0;
    kif.key_mode_in  = 2'b00;
    kif.kb_key_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_key_ready", kif.key_ready, 1);
    chk("rst_key_done", kif.key_done, 0);
    chk("rst_key_err", kif.key_err, 0);
    chk("rst_busy", kif.busy, 0);
    chk("rst_kb_key", kif.kb_key, 0);
    chk("rst_kb_mode", kif.kb_key_mode, 0);
    chk("rst_kb_start", kif.kb_start, 0);
    resetN = 1'b1;
    @(negedge clk);

    // Mode 00 with an all-ones key; ready low for 10 cycles.
    send({256{1'b1}}, 2'b00, 1'b0);
    chk("t2_start", kif.kb_start, 1);
    chk("t2_kb_key", kif.kb_key, {{128{1'b0}}, {128{1'b1}}});
    kif.kb_key_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_no_done", kif.key_done, 0);
      chk("t2_no_restart", kif.kb_start, 0);
    end
    kif.kb_key_ready = 1'b1;
    @(negedge clk);
    chk("t2_done", kif.key_done, 1);
    @(negedge clk);
    chk("t2_done_single", kif.key_done, 0);
    chk("t2_idle_ready", kif.key_ready, 1);
    chk("t2_idle_busy", kif.busy, 0);
    chk("t2_kb_key_held", kif.kb_key, {{128{1'b0}}, {128{1'b1}}});

    // Illegal mode: flagged, nothing started; next legal request clears the flag.
    ns = n_start;
    send({8{32'hDEADBEEF}}, 2'b11, 1'b0);
    chk("t3_err", kif.key_err, 1);
    chk("t3_still_idle", kif.key_ready, 1);
    chk("t3_not_busy", kif.busy, 0);
    chk("t3_kb_key_kept", kif.kb_key, {{128{1'b0}}, {128{1'b1}}});
    repeat (3) @(negedge clk);
    chk("t3_no_start", n_start, ns);
    chk("t3_err_sticky", kif.key_err, 1);
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send(k, 2'b01, 1'b0);
    chk("t3_err_cleared", kif.key_err, 0);
    quick_complete();
    @(negedge clk);

    // Stale ready high through START must not complete the load.
    nd = n_done;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send(k, 2'b10, 1'b0);
    chk("t4_start", kif.kb_start, 1);
    @(negedge clk);
    chk("t4_no_done_stale", kif.key_done, 0);
    chk("t4_busy", kif.busy, 1);
    kif.kb_key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_no_done_low", kif.key_done, 0);
    end
    kif.kb_key_ready = 1'b1;
    @(negedge clk);
    chk("t4_done", kif.key_done, 1);
    repeat (3) @(negedge clk);
    chk("t4_one_done", n_done, nd + 1);

`ifdef KEYLOAD_TIMEOUT_EN
    // Ready never rises: abort on the 16th WAIT_RDY cycle.
    nd = n_done;
    send({4{64'h0123456789ABCDEF}}, 2'b10, 1'b0);
    kif.kb_key_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk("t5_still_waiting", kif.busy, 1);
      chk("t5_no_err_yet", kif.key_err, 0);
    end
    @(negedge clk);
    chk("t5_err", kif.key_err, 1);
    chk("t5_idle", kif.busy, 0);
    chk("t5_key_ready", kif.key_ready, 1);
    chk("t5_no_done", kif.key_done, 0);
    void'(done_q.pop_back());
    kif.kb_key_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_no_done_count", n_done, nd);
`endif

    // key_valid held high over three back-to-back mode 10 requests.
    ns = n_start;
    nd = n_done;
    for (int i = 0; i < 3; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 32'(i)};
      send(k, 2'b10, 1'b1);
      chk("t6_err_clear", kif.key_err, 0);
      quick_complete();
    end
    kif.key_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_three_starts", n_start, ns + 3);
    chk("t6_three_dones", n_done, nd + 3);

    // Reset held three cycles while waiting for ready to rise.
    nd = n_done;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send(k, 2'b01, 1'b0);
    kif.kb_key_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_in_wait", kif.busy, 1);
    resetN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_no_done", kif.key_done, 0);
    end
    chk("t1_key_ready", kif.key_ready, 1);
    chk("t1_key_err", kif.key_err, 0);
    chk("t1_busy", kif.busy, 0);
    chk("t1_kb_key_zero", kif.kb_key, 0);
    chk("t1_kb_mode_zero", kif.kb_key_mode, 0);
    chk("t1_kb_start", kif.kb_start, 0);
    done_q.delete();
    kif.kb_key_ready = 1'b1;
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_after_rst_idle", kif.key_ready, 1);
    chk("t1_after_rst_no_done", n_done, nd);

    chk("sb_start_q_empty", start_q.size(), 0);
    chk("sb_done_q_empty", done_q.size(), 0);
    chk("sb_start_total", n_start, exp_starts);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
